// File: rtl/sprite_line_scheduler_pkg.sv
// Shared VGA geometry defaults and the scanline scheduler FSM state type.
package sprite_line_scheduler_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned BOX_W    = 32;
  localparam int unsigned BOX_H    = 32;
  localparam int unsigned N_OBJ    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/sprite_line_scheduler_slot_insert.sv
// Combinational lowest-free-slot finder for the pending slot set.
module sprite_line_scheduler_slot_insert #(
  parameter int unsigned SLOTS = 2
) (
  input  logic [SLOTS-1:0] used_i,
  output logic             free_o,
  output logic [SLOTS-1:0] pick_o
);

  always_comb begin
    logic found;
    found  = 1'b0;
    pick_o = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (!used_i[i] && !found) begin
        pick_o[i] = 1'b1;
        found     = 1'b1;
      end
    end
    free_o = found;
  end

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline object scheduler: walks the object table during h-blank and
// fills a pending slot set that is committed to the active set at line_start.
module sprite_line_scheduler
  import sprite_line_scheduler_pkg::*;
#(
  parameter int unsigned N_OBJ    = sprite_line_scheduler_pkg::N_OBJ,
  parameter int unsigned SLOTS    = 2,
  parameter int unsigned BOX_H    = sprite_line_scheduler_pkg::BOX_H,
  parameter int unsigned SCREEN_H = sprite_line_scheduler_pkg::SCREEN_H,
  localparam int unsigned IW      = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  line_start,
  input  logic [8:0]            next_y,
  output logic                  obj_req,
  output logic [IW-1:0]         obj_idx,
  input  logic                  obj_ack,
  input  logic [8:0]            obj_y,
  input  logic [9:0]            obj_x,
  output logic [SLOTS-1:0]      act_valid,
  output logic [IW*SLOTS-1:0]   act_idx,
  output logic [10*SLOTS-1:0]   act_x,
  output logic                  act_ovf,
  output logic                  act_late,
  output logic                  busy
);

  localparam logic [IW-1:0] IDX_LAST   = IW'(N_OBJ - 1);
  localparam logic [9:0]    BOX_H10    = 10'(BOX_H);
  localparam logic [9:0]    SCREEN_H10 = 10'(SCREEN_H);

  sched_state_e state_q, state_d;
  logic [8:0]                ty_q, ty_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic                      req_q, req_d;
  logic                      busy_q, busy_d;

  logic [SLOTS-1:0]          pv_q, pv_d;
  logic [SLOTS-1:0][IW-1:0]  pidx_q, pidx_d;
  logic [SLOTS-1:0][9:0]     px_q, px_d;
  logic                      povf_q, povf_d;
  logic                      plate_q, plate_d;

  logic [SLOTS-1:0]          av_q, av_d;
  logic [SLOTS-1:0][IW-1:0]  aidx_q, aidx_d;
  logic [SLOTS-1:0][9:0]     ax_q, ax_d;
  logic                      aovf_q, aovf_d;
  logic                      alate_q, alate_d;

  logic                      slot_free;
  logic [SLOTS-1:0]          slot_pick;
  logic [9:0]                ty10, oy10;
  logic                      hit;

  sprite_line_scheduler_slot_insert #(.SLOTS(SLOTS)) u_slot_insert (
    .used_i (pv_q),
    .free_o (slot_free),
    .pick_o (slot_pick)
  );

  // Widened to 10 bits so obj_y + BOX_H cannot wrap for boxes near the bottom.
  assign ty10 = {1'b0, ty_q};
  assign oy10 = {1'b0, obj_y};
  assign hit  = (ty10 >= oy10) && (ty10 < (oy10 + BOX_H10));

  always_comb begin
    state_d = state_q;
    ty_d    = ty_q;
    idx_d   = idx_q;
    req_d   = req_q;
    busy_d  = busy_q;
    pv_d    = pv_q;
    pidx_d  = pidx_q;
    px_d    = px_q;
    povf_d  = povf_q;
    plate_d = plate_q;
    av_d    = av_q;
    aidx_d  = aidx_q;
    ax_d    = ax_q;
    aovf_d  = aovf_q;
    alate_d = alate_q;

    if (line_start) begin
      // A line_start mid-fetch commits the partial set flagged late and restarts.
      av_d    = pv_q;
      aidx_d  = pidx_q;
      ax_d    = px_q;
      aovf_d  = povf_q;
      alate_d = plate_q | (state_q == ST_FETCH);
      pv_d    = '0;
      pidx_d  = '0;
      px_d    = '0;
      povf_d  = 1'b0;
      plate_d = 1'b0;
      ty_d    = next_y;
      idx_d   = IDX_LAST;
      busy_d  = 1'b1;
      if ({1'b0, next_y} >= SCREEN_H10) begin
        state_d = ST_DONE;
        req_d   = 1'b0;
      end else begin
        state_d = ST_FETCH;
        req_d   = 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          if (obj_ack) begin
            if (hit) begin
              if (slot_free) begin
                for (int unsigned i = 0; i < SLOTS; i++) begin
                  if (slot_pick[i]) begin
                    pv_d[i]   = 1'b1;
                    pidx_d[i] = idx_q;
                    px_d[i]   = obj_x;
                  end
                end
              end else begin
                povf_d = 1'b1;
              end
            end
            if (idx_q == '0) begin
              state_d = ST_DONE;
              req_d   = 1'b0;
            end else begin
              idx_d = idx_q - IW'(1);
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
        default: begin
          req_d  = 1'b0;
          busy_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ty_q    <= '0;
      idx_q   <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      pv_q    <= '0;
      pidx_q  <= '0;
      px_q    <= '0;
      povf_q  <= 1'b0;
      plate_q <= 1'b0;
      av_q    <= '0;
      aidx_q  <= '0;
      ax_q    <= '0;
      aovf_q  <= 1'b0;
      alate_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ty_q    <= ty_d;
      idx_q   <= idx_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      pv_q    <= pv_d;
      pidx_q  <= pidx_d;
      px_q    <= px_d;
      povf_q  <= povf_d;
      plate_q <= plate_d;
      av_q    <= av_d;
      aidx_q  <= aidx_d;
      ax_q    <= ax_d;
      aovf_q  <= aovf_d;
      alate_q <= alate_d;
    end
  end

  assign obj_req   = req_q;
  assign obj_idx   = idx_q;
  assign busy      = busy_q;
  assign act_valid = av_q;
  assign act_idx   = aidx_q;
  assign act_x     = ax_q;
  assign act_ovf   = aovf_q;
  assign act_late  = alate_q;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed bench for sprite_line_scheduler with a per-line behavioural model.
module tb_sprite_line_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       line_start;
  logic [8:0] next_y;
  logic       obj_req;
  logic [1:0] obj_idx;
  logic       obj_ack = 1'b0;
  logic [8:0] obj_y = '0;
  logic [9:0] obj_x = '0;
  logic [1:0] act_valid;
  logic [3:0] act_idx;
  logic [19:0] act_x;
  logic       act_ovf;
  logic       act_late;
  logic       busy;

  sprite_line_scheduler #(.N_OBJ(4), .SLOTS(2), .BOX_H(32), .SCREEN_H(480)) dut (
    .clk        (clk),
    .rst        (rst),
    .line_start (line_start),
    .next_y     (next_y),
    .obj_req    (obj_req),
    .obj_idx    (obj_idx),
    .obj_ack    (obj_ack),
    .obj_y      (obj_y),
    .obj_x      (obj_x),
    .act_valid  (act_valid),
    .act_idx    (act_idx),
    .act_x      (act_x),
    .act_ovf    (act_ovf),
    .act_late   (act_late),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ty_t[4];
  int tx_t[4];
  bit tied = 1'b1;
  int dly  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Table responder: ack after dly stall cycles, or ack tied high.
  always @(posedge clk) begin
    static int  wcnt = 0;
    static bit  preq = 1'b0;
    static bit  pack = 1'b0;
    static logic [1:0] pidx = '0;
    bit ack;
    #1;
    if (obj_req && preq && !pack && obj_idx == pidx) wcnt++;
    else wcnt = 0;
    ack     = tied ? 1'b1 : (obj_req && wcnt >= dly);
    obj_ack = ack;
    obj_y   = 9'(ty_t[obj_idx]);
    obj_x   = 10'(tx_t[obj_idx]);
    preq    = obj_req;
    pack    = ack;
    pidx    = obj_idx;
  end

  // Model: each scan is summarised as hit list in scan order; at the next
  // line_start the objects actually acked before it are turned into slots.
  int  cyc = 0;
  int  ls_edge = 0;
  bit  scan_on = 1'b0;
  bit  s_valid = 1'b0;
  int  s_d = 0;
  bit  s_hit[4];
  int  s_x[4];
  logic [1:0] e_av = '0;
  logic [1:0] e_ai[2] = '{2'd0, 2'd0};
  logic [9:0] e_ax[2] = '{10'd0, 10'd0};
  logic       e_ovf = 1'b0;
  logic       e_late = 1'b0;

  always @(posedge clk) begin
    int gap, k, n;
    cyc = cyc + 1;
    if (rst) begin
      scan_on = 1'b0;
      e_av = '0; e_ai[0] = '0; e_ai[1] = '0; e_ax[0] = '0; e_ax[1] = '0;
      e_ovf = 1'b0; e_late = 1'b0;
    end else if (line_start) begin
      gap = cyc - ls_edge;
      e_av = '0; e_ai[0] = '0; e_ai[1] = '0; e_ax[0] = '0; e_ax[1] = '0;
      e_ovf = 1'b0; e_late = 1'b0;
      n = 0;
      if (scan_on && s_valid) begin
        k = (gap - 1) / (s_d + 1);
        if (k > 4) k = 4;
        e_late = (gap <= 4 * (s_d + 1));
        for (int j = 0; j < k; j++) begin
          if (s_hit[j]) begin
            if (n < 2) begin
              e_av[n] = 1'b1;
              e_ai[n] = 2'(3 - j);
              e_ax[n] = 10'(s_x[j]);
            end else begin
              e_ovf = 1'b1;
            end
            n++;
          end
        end
      end
      s_valid = (int'(next_y) < 480);
      s_d     = tied ? 0 : dly;
      for (int j = 0; j < 4; j++) begin
        s_hit[j] = (int'(next_y) >= ty_t[3-j]) && (int'(next_y) < ty_t[3-j] + 32);
        s_x[j]   = tx_t[3-j];
      end
      ls_edge = cyc;
      scan_on = 1'b1;
    end
  end

  always @(negedge clk) begin
    int e;
    bit exp_req, exp_busy;
    if (chk_en) begin
      e        = cyc - ls_edge;
      exp_req  = scan_on && s_valid && (e < 4 * (s_d + 1));
      exp_busy = scan_on && (s_valid ? (e <= 4 * (s_d + 1)) : (e == 0));
      chk("obj_req", 32'(obj_req), 32'(exp_req));
      chk("busy", 32'(busy), 32'(exp_busy));
      if (exp_req) chk("obj_idx", 32'(obj_idx), 32'(3 - e / (s_d + 1)));
      chk("act_valid", 32'(act_valid), 32'(e_av));
      chk("act_idx", 32'(act_idx), 32'({e_ai[1], e_ai[0]}));
      chk("act_x", 32'(act_x), 32'({e_ax[1], e_ax[0]}));
      chk("act_ovf", 32'(act_ovf), 32'(e_ovf));
      chk("act_late", 32'(act_late), 32'(e_late));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic line(input int y);
    line_start = 1'b1;
    next_y     = 9'(y);
    tick(1);
    line_start = 1'b0;
  endtask

  task automatic set_tab(input int y0, y1, y2, y3, x0, x1, x2, x3);
    ty_t[0] = y0; ty_t[1] = y1; ty_t[2] = y2; ty_t[3] = y3;
    tx_t[0] = x0; tx_t[1] = x1; tx_t[2] = x2; tx_t[3] = x3;
  endtask

  initial begin
    int c_busy, c_req;
    rst = 1'b1;
    line_start = 1'b0;
    next_y = '0;
    set_tab(0, 0, 0, 0, 0, 0, 0, 0);
    tick(3);
    rst = 1'b0;
    chk("reset act_valid", 32'(act_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset obj_req", 32'(obj_req), 32'd0);
    chk_en = 1'b1;

    // Two hits (idx2 at 116, idx1 at 100) on line 120.
    set_tab(0, 100, 116, 300, 5, 105, 205, 305);
    line(120);
    c_busy = 0;
    for (int i = 0; i < 8; i++) begin
      c_busy += int'(busy);
      tick(1);
    end
    chk("busy cycles", 32'(c_busy), 32'd5);
    line(479);
    chk("t1 valid", 32'(act_valid), 32'h3);
    chk("t1 idx", 32'(act_idx), 32'h6);
    chk("t1 x", 32'(act_x), {12'd0, 10'd105, 10'd205});
    chk("t1 ovf", 32'(act_ovf), 32'd0);
    tick(8);

    // Three hits, two slots: lowest index dropped.
    set_tab(0, 200, 200, 200, 7, 17, 27, 37);
    line(210);
    tick(8);
    line(479);
    chk("t2 idx", 32'(act_idx), 32'hB);
    chk("t2 x", 32'(act_x), {12'd0, 10'd27, 10'd37});
    chk("t2 ovf", 32'(act_ovf), 32'd1);
    tick(8);

    // Bottom-of-screen boundaries.
    set_tab(0, 0, 0, 448, 1, 2, 3, 600);
    line(479);
    tick(8);
    line(480);
    chk("t3 hit valid", 32'(act_valid), 32'h1);
    chk("t3 hit slot0", {22'd0, act_x[9:0]}, 32'd600);
    c_busy = 0;
    c_req = 0;
    for (int i = 0; i < 6; i++) begin
      c_busy += int'(busy);
      c_req  += int'(obj_req);
      tick(1);
    end
    chk("t3 offscreen req", 32'(c_req), 32'd0);
    chk("t3 offscreen busy", 32'(c_busy), 32'd1);
    set_tab(0, 0, 0, 100, 1, 2, 3, 600);
    line(132);
    chk("t3 offscreen commit", 32'(act_valid), 32'd0);
    tick(8);
    line(479);
    chk("t3 miss", 32'(act_valid), 32'd0);
    tick(8);

    // Three stall cycles per request.
    set_tab(0, 100, 116, 300, 5, 105, 205, 305);
    tied = 1'b0;
    dly  = 3;
    line(120);
    c_busy = 0;
    c_req = 0;
    for (int i = 0; i < 24; i++) begin
      c_busy += int'(busy);
      c_req  += int'(obj_req);
      tick(1);
    end
    chk("t4 busy cycles", 32'(c_busy), 32'd17);
    chk("t4 req cycles", 32'(c_req), 32'd16);
    line(479);
    chk("t4 idx", 32'(act_idx), 32'h6);
    tick(20);
    tied = 1'b1;
    dly  = 0;

    // Restart two cycles into a scan.
    set_tab(0, 200, 200, 200, 7, 17, 27, 37);
    line(210);
    tick(1);
    line(210);
    chk("t5 late", 32'(act_late), 32'd1);
    chk("t5 valid", 32'(act_valid), 32'h1);
    chk("t5 slot0", {22'd0, act_x[9:0]}, 32'd37);
    chk("t5 restart idx", 32'(obj_idx), 32'd3);
    tick(8);
    line(479);
    chk("t5 full idx", 32'(act_idx), 32'hB);
    chk("t5 full late", 32'(act_late), 32'd0);
    tick(8);

    // Reset mid-scan with a populated active set.
    line(210);
    tick(8);
    line(210);
    chk("t6 pre valid", 32'(act_valid), 32'h3);
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t6 req", 32'(obj_req), 32'd0);
    chk("t6 busy", 32'(busy), 32'd0);
    chk("t6 act", {act_valid, act_idx, act_ovf, act_late}, 32'd0);
    chk("t6 act_x", 32'(act_x), 32'd0);
    line(210);
    chk("t6 post valid", 32'(act_valid), 32'd0);
    tick(8);
    line(479);
    chk("t6 rescan idx", 32'(act_idx), 32'hB);
    tick(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
